alu_cmd_packer: RTL and testbench
=================================

Name: alu_cmd_packer

Overview:
- Host-side initiator for the UART ALU packet protocol. Accepts one command (opcode + operand count) and a stream of operand words.
- Emits the framed byte stream the ALU parses: opcode, reserved 0x00, 16-bit total length (LSB first), then operand bytes LSB first.
- The byte output drives a uart_tx-style AXI-Stream byte sink (data/valid/ready).
- Used in bench/host-emulation logic and in loopback test designs opposite uart_alu.

Parameters:
- OperandWidth, 32, operand word width in bits; must be a nonzero multiple of 8.
- CountWidth, 8, width of the operand count; max count = 2**CountWidth-1. Total length must fit in 16 bits; elaboration error otherwise.

Ports:
- clk_i  in  1  clock
- reset_i  in  1  synchronous reset, active-low (asserted when 0)
- opcode_i  in  8  command opcode
- count_i  in  CountWidth  number of operand words to follow
- cmd_valid_i  in  1  command valid
- cmd_ready_o  out  1  command accepted when valid&ready
- operand_i  in  OperandWidth  operand word
- operand_valid_i  in  1  operand valid
- operand_ready_o  out  1  operand accepted when valid&ready
- data_o  out  8  output byte
- valid_o  out  1  output byte valid
- ready_i  in  1  sink ready
- busy_o  out  1  packet in progress

Behaviour:
- Reset (reset_i==0 at a rising edge):
  - state=IDLE; valid_o=0, data_o=0, busy_o=0.
  - Word buffer empty; counters cleared.
  - cmd_ready_o=1 from the first cycle after reset release. operand_ready_o=0.
- Length field: len = 4 + count*(OperandWidth/8), computed at command accept and registered.
- States: IDLE, OPC, RSV, LEN_LO, LEN_HI, DATA.
- IDLE:
  - cmd_ready_o=1.
  - On cmd handshake: latch opcode, count and len; go to OPC.
  - Next cycle: valid_o=1, data_o=opcode, busy_o=1.
- Byte output is registered:
  - valid_o stays high and data_o stays stable until ready_i=1.
  - One byte advances per cycle while ready_i=1. No combinational path from ready_i to valid_o or data_o.
- Header sequence: OPC -> RSV (0x00) -> LEN_LO (len[7:0]) -> LEN_HI (len[15:8]). Each transition happens on an output handshake.
- After LEN_HI handshake:
  - count==0: go to IDLE, valid_o=0.
  - Otherwise: go to DATA.
- DATA:
  - One-word buffer. Bytes are sent LSB first, with a byte index 0..OperandWidth/8-1.
  - operand_ready_o = (state==DATA or LEN_HI handshake this cycle) && words_remaining>0 && (buffer empty || last byte of buffer handshaking this cycle).
  - This gives gap-free output when operands are available. operand_ready_o never depends on operand_valid_i.
  - If the buffer is empty and no operand is valid: valid_o=0 (bubble), stay in DATA.
  - After the last byte of the last word handshakes: go to IDLE, busy_o=0, valid_o=0.
- cmd_ready_o=0 in all states except IDLE. Back-to-back command accept occurs the cycle after the last byte handshake.
- Operands presented outside DATA are not accepted (operand_ready_o=0).
- Reset mid-packet:
  - Packet aborted; the next cycle shows valid_o=0 and state IDLE.
  - The partial packet is not resumed. Any buffered operand is discarded.
- Throughput: packet of count words, with ready_i and operand_valid_i held high, occupies exactly 4+count*OperandWidth/8 consecutive valid_o cycles.

Decomposition:
- Package alu_pkt_pkg:
  - HeaderBytes=4 and ReservedByte=8'h00.
  - State enum alu_pkt_state_e.
  - Length-compute function shared with uart_alu's parser.
- One natural sub-module: word_serializer. It holds the one-word buffer and byte index, takes a word via ready/valid, emits bytes LSB first, and flags last byte.
- The packer FSM muxes header bytes vs serializer output into the output byte register.

Test Plan:
- OperandWidth=8; opcode 0xec, count 2, operands 0x42, 0x69; ready_i=1 -> bytes ec 00 06 00 42 69 on 6 consecutive valid cycles, busy_o falls after the last byte.
- OperandWidth=32; opcode 0x10, count 2, operands 0x11223344, 0xAABBCCDD -> 10 00 0c 00 44 33 22 11 dd cc bb aa, no bubbles, operand_ready_o pulses exactly twice.
- count 0, opcode 0x05 -> 05 00 04 00, then cmd_ready_o=1 the next cycle; operand_ready_o never asserted.
- Random ready_i backpressure (~50%) and operand_valid_i gaps -> byte sequence identical to the no-stall case; data_o stable whenever valid_o&&!ready_i; bubbles only while the buffer is empty.
- reset_i=0 for one cycle during byte 5 of a 12-byte packet -> valid_o=0 next cycle, state IDLE; a new command sends a correct full packet.
- Loopback through uart_tx/uart_rx (prescale 1) into uart_alu -> uart_alu receives the same byte sequence as the directed case.

Source files
------------

// File: rtl/alu_pkt_pkg.sv
// Shared definitions for the UART ALU packet framing: header layout,
// packer state encoding and the total-length helper used by both the
// host-side packer and the ALU-side parser.
package alu_pkt_pkg;

  localparam int         HeaderBytes  = 4;
  localparam logic [7:0] ReservedByte = 8'h00;

  // State names the byte currently held in the output register.
  typedef enum logic [2:0] {
    IDLE,
    OPC,
    RSV,
    LEN_LO,
    LEN_HI,
    DATA
  } alu_pkt_state_e;

  // Total packet length in bytes, header included.
  function automatic logic [15:0] pkt_len(input int count, input int bytes_per_word);
    return 16'(HeaderBytes + count * bytes_per_word);
  endfunction

endpackage

// File: rtl/word_serializer.sv
// One-word operand buffer. Byte 0 of a loaded word is forwarded straight
// to the packer's output register on the load cycle; this block keeps the
// remaining bytes and hands them out LSB first, one per take.
module word_serializer #(
  parameter int WordWidth = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 load,
  input  logic [WordWidth-1:0] word,
  input  logic                 take,
  output logic                 full,
  output logic                 last,
  output logic [7:0]           next_byte
);

  localparam int Bytes = WordWidth / 8;
  localparam int LeftW = $clog2(Bytes + 1);

  // Bytes of the current word not yet accepted by the sink, counting the
  // one on the output register.
  logic [LeftW-1:0]     left;
  logic [WordWidth-1:0] rest;

  // Load wins over take so a new word can land on the last byte's handshake.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      left <= '0;
      rest <= '0;
    end else if (load) begin
      left <= LeftW'(Bytes);
      rest <= word >> 8;
    end else if (take && full) begin
      left <= left - LeftW'(1);
      rest <= rest >> 8;
    end
  end

  assign full      = (left != '0);
  assign last      = (left == LeftW'(1));
  assign next_byte = rest[7:0];

endmodule

// File: rtl/alu_cmd_packer.sv
// Host-side framer for the UART ALU protocol: takes a command and a stream
// of operand words and emits opcode, reserved byte, 16-bit length (LSB
// first) and the operand bytes LSB first on a registered byte stream.
module alu_cmd_packer
  import alu_pkt_pkg::*;
#(
  parameter int OperandWidth = 32,
  parameter int CountWidth   = 8
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic [7:0]              opcode_i,
  input  logic [CountWidth-1:0]   count_i,
  input  logic                    cmd_valid_i,
  output logic                    cmd_ready_o,
  input  logic [OperandWidth-1:0] operand_i,
  input  logic                    operand_valid_i,
  output logic                    operand_ready_o,
  output logic [7:0]              data_o,
  output logic                    valid_o,
  input  logic                    ready_i,
  output logic                    busy_o
);

  localparam int BytesPerWord = OperandWidth / 8;
  localparam int MaxLen       = HeaderBytes + (2 ** CountWidth - 1) * BytesPerWord;

  if (OperandWidth == 0 || OperandWidth % 8 != 0) begin : g_bad_width
    $error("alu_cmd_packer: OperandWidth must be a nonzero multiple of 8");
  end
  if (MaxLen > 65535) begin : g_bad_len
    $error("alu_cmd_packer: largest packet does not fit a 16-bit length");
  end

  alu_pkt_state_e        state, state_d;
  logic [7:0]            data_d;
  logic                  valid_d;
  logic [15:0]           len_q, len_d;
  logic [CountWidth-1:0] rem_q, rem_d;

  logic       hs, op_hs;
  logic       ser_full, ser_last, ser_take;
  logic [7:0] ser_byte;
  logic       feed_valid;
  logic [7:0] feed_data;

  assign hs     = valid_o & ready_i;
  assign busy_o = (state != IDLE);

  // Gated by reset so nothing looks acceptable while reset is held.
  assign cmd_ready_o = (state == IDLE) && reset_i;

  // A word may enter when the buffer is empty or frees up on this very
  // handshake; the LEN_HI term lets the first word arrive without a bubble.
  assign operand_ready_o = ((state == DATA) || (state == LEN_HI && hs)) &&
                           (rem_q != '0) && (!ser_full || (ser_last && hs));
  assign op_hs    = operand_ready_o & operand_valid_i;
  assign ser_take = (state == DATA) && hs;

  // Next data byte: first byte of an arriving word, else the buffer's next.
  assign feed_valid = op_hs || (ser_full && !ser_last);
  assign feed_data  = op_hs ? operand_i[7:0] : ser_byte;

  word_serializer #(
    .WordWidth(OperandWidth)
  ) u_ser (
    .clk      (clk_i),
    .rst_n    (reset_i),
    .load     (op_hs),
    .word     (operand_i),
    .take     (ser_take),
    .full     (ser_full),
    .last     (ser_last),
    .next_byte(ser_byte)
  );

  // Next-state and next output byte; each header step moves on a handshake.
  always_comb begin
    state_d = state;
    data_d  = data_o;
    valid_d = valid_o;
    len_d   = len_q;
    rem_d   = rem_q;
    if (op_hs) rem_d = rem_q - CountWidth'(1);
    case (state)
      IDLE: begin
        if (cmd_valid_i && cmd_ready_o) begin
          state_d = OPC;
          data_d  = opcode_i;
          valid_d = 1'b1;
          len_d   = pkt_len(32'(count_i), BytesPerWord);
          rem_d   = count_i;
        end
      end
      OPC: begin
        if (hs) begin
          state_d = RSV;
          data_d  = ReservedByte;
        end
      end
      RSV: begin
        if (hs) begin
          state_d = LEN_LO;
          data_d  = len_q[7:0];
        end
      end
      LEN_LO: begin
        if (hs) begin
          state_d = LEN_HI;
          data_d  = len_q[15:8];
        end
      end
      LEN_HI: begin
        if (hs) begin
          if (rem_q == '0) begin
            state_d = IDLE;
            valid_d = 1'b0;
          end else begin
            state_d = DATA;
            valid_d = feed_valid;
            if (feed_valid) data_d = feed_data;
          end
        end
      end
      DATA: begin
        if (hs && ser_last && rem_q == '0) begin
          state_d = IDLE;
          valid_d = 1'b0;
        end else if (hs || !valid_o) begin
          valid_d = feed_valid;
          if (feed_valid) data_d = feed_data;
        end
      end
      default: begin
        state_d = IDLE;
        valid_d = 1'b0;
      end
    endcase
  end

  // State, output byte register and packet counters.
  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      state   <= IDLE;
      data_o  <= '0;
      valid_o <= 1'b0;
      len_q   <= '0;
      rem_q   <= '0;
    end else begin
      state   <= state_d;
      data_o  <= data_d;
      valid_o <= valid_d;
      len_q   <= len_d;
      rem_q   <= rem_d;
    end
  end

endmodule

// File: tb/tb_alu_cmd_packer.sv
// Directed bench for alu_cmd_packer: a 32-bit and an 8-bit operand instance,
// driven from a vector table, with stall, gap and mid-packet reset cases.
module tb_alu_cmd_packer;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset_i;

  logic [7:0]  opcode, count, data;
  logic        cmd_valid, cmd_ready, operand_valid, operand_ready, valid, ready, busy;
  logic [31:0] operand;

  logic [7:0]  opcode8, count8, data8, operand8;
  logic        cmd_valid8, cmd_ready8, operand_valid8, operand_ready8, valid8, ready8, busy8;

  alu_cmd_packer #(.OperandWidth(32), .CountWidth(8)) dut (
    .clk_i(clk), .reset_i(reset_i), .opcode_i(opcode), .count_i(count),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .operand_i(operand),
    .operand_valid_i(operand_valid), .operand_ready_o(operand_ready),
    .data_o(data), .valid_o(valid), .ready_i(ready), .busy_o(busy));

  alu_cmd_packer #(.OperandWidth(8), .CountWidth(8)) dut8 (
    .clk_i(clk), .reset_i(reset_i), .opcode_i(opcode8), .count_i(count8),
    .cmd_valid_i(cmd_valid8), .cmd_ready_o(cmd_ready8), .operand_i(operand8),
    .operand_valid_i(operand_valid8), .operand_ready_o(operand_ready8),
    .data_o(data8), .valid_o(valid8), .ready_i(ready8), .busy_o(busy8));

  typedef struct packed {
    logic             w8;
    logic [7:0]       opc;
    logic [7:0]       cnt;
    logic [3:0][31:0] ops;
    logic [15:0]      len;
    logic             stall;
    logic             gaps;
    logic [7:0]       abort_at;
  } vec_t;

  int checks = 0;
  int errors = 0;
  logic [7:0] got[$];
  vec_t vecs[10];

  function automatic vec_t mk(input logic w8, input logic [7:0] opc, input logic [7:0] cnt,
                              input logic [31:0] o0, input logic [31:0] o1,
                              input logic [31:0] o2, input logic [31:0] o3,
                              input logic [15:0] len, input logic stall, input logic gaps,
                              input logic [7:0] abort_at);
    vec_t v;
    v.w8 = w8; v.opc = opc; v.cnt = cnt;
    v.ops = {o3, o2, o1, o0};
    v.len = len; v.stall = stall; v.gaps = gaps; v.abort_at = abort_at;
    return v;
  endfunction

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  task automatic drive(input logic w8, input logic [7:0] opc, input logic [7:0] cnt,
                       input logic cv, input logic [31:0] op, input logic ov, input logic rdy);
    if (w8) begin
      opcode8 = opc; count8 = cnt; cmd_valid8 = cv; operand8 = op[7:0];
      operand_valid8 = ov; ready8 = rdy;
      cmd_valid = 1'b0; operand_valid = 1'b0; ready = 1'b1;
    end else begin
      opcode = opc; count = cnt; cmd_valid = cv; operand = op;
      operand_valid = ov; ready = rdy;
      cmd_valid8 = 1'b0; operand_valid8 = 1'b0; ready8 = 1'b1;
    end
  endtask

  task automatic run_pkt(input vec_t v, input string tag);
    int bpw, exp_n, oi, n_valid, n_busy, n_oprdy, k;
    bit accepted, done, prev_stall;
    logic [7:0] prev_data, s_data;
    logic s_valid, s_ready, s_busy, s_cr, s_or, s_ov, s_cv;
    logic [31:0] word;
    logic [7:0] exp_b[$];
    bpw = v.w8 ? 1 : 4;
    exp_n = 4 + int'(v.cnt) * bpw;
    oi = 0; n_valid = 0; n_busy = 0; n_oprdy = 0;
    accepted = 0; done = 0; prev_stall = 0; prev_data = '0;
    got.delete();
    @(posedge clk); #1;
    drive(v.w8, v.opc, v.cnt, 1'b1, v.ops[0], v.cnt != 0, 1'b1);
    for (int cyc = 0; cyc < 400 && !done; cyc++) begin
      @(negedge clk);
      s_valid = v.w8 ? valid8 : valid;
      s_data  = v.w8 ? data8 : data;
      s_ready = v.w8 ? ready8 : ready;
      s_busy  = v.w8 ? busy8 : busy;
      s_cr    = v.w8 ? cmd_ready8 : cmd_ready;
      s_cv    = v.w8 ? cmd_valid8 : cmd_valid;
      s_or    = v.w8 ? operand_ready8 : operand_ready;
      s_ov    = v.w8 ? operand_valid8 : operand_valid;
      if (prev_stall) begin
        check({tag, " stall valid held"}, int'(s_valid), 1);
        check({tag, " stall data stable"}, int'(s_data), int'(prev_data));
      end
      prev_stall = s_valid && !s_ready;
      prev_data  = s_data;
      if (s_valid) n_valid++;
      if (s_busy) n_busy++;
      if (s_or) n_oprdy++;
      if (s_valid && s_ready) got.push_back(s_data);
      if (s_or && s_ov) oi++;
      if (accepted && !s_busy) begin
        done = 1;
        check({tag, " cmd_ready after packet"}, int'(s_cr), 1);
      end
      if (s_cv && s_cr) accepted = 1;
      if (v.abort_at != 0 && got.size() == int'(v.abort_at)) begin
        @(posedge clk); #1;
        reset_i = 1'b0;
        drive(v.w8, 8'h00, 8'h00, 1'b0, 32'h0, 1'b0, 1'b1);
        @(posedge clk); #1;
        reset_i = 1'b1;
        @(negedge clk);
        check({tag, " abort valid"}, int'(v.w8 ? valid8 : valid), 0);
        check({tag, " abort busy"}, int'(v.w8 ? busy8 : busy), 0);
        check({tag, " abort cmd_ready"}, int'(v.w8 ? cmd_ready8 : cmd_ready), 1);
        check({tag, " abort operand_ready"}, int'(v.w8 ? operand_ready8 : operand_ready), 0);
        return;
      end
      if (!done) begin
        @(posedge clk); #1;
        word = (oi < int'(v.cnt)) ? v.ops[oi] : 32'h0;
        drive(v.w8, v.opc, v.cnt, !accepted, word,
              (oi < int'(v.cnt)) && (v.gaps ? 1'($urandom_range(0, 1)) : 1'b1),
              v.stall ? 1'($urandom_range(0, 1)) : 1'b1);
      end
    end
    drive(v.w8, 8'h00, 8'h00, 1'b0, 32'h0, 1'b0, 1'b1);
    if (!done) check({tag, " timeout"}, 0, 1);
    exp_b.push_back(v.opc);
    exp_b.push_back(8'h00);
    exp_b.push_back(v.len[7:0]);
    exp_b.push_back(v.len[15:8]);
    for (int i = 0; i < int'(v.cnt); i++) begin
      word = v.ops[i];
      for (int b = 0; b < bpw; b++) exp_b.push_back(word[8*b +: 8]);
    end
    check({tag, " byte count"}, got.size(), exp_n);
    for (int i = 0; i < exp_b.size(); i++) begin
      k = (i < got.size()) ? int'(got[i]) : -1;
      check($sformatf("%s byte %0d", tag, i), k, int'(exp_b[i]));
    end
    if (!v.gaps) check({tag, " operand_ready cycles"}, n_oprdy, int'(v.cnt));
    if (!v.gaps && !v.stall) begin
      check({tag, " valid cycles"}, n_valid, exp_n);
      check({tag, " busy cycles"}, n_busy, exp_n);
    end
  endtask

  initial begin
    vecs[0] = mk(1, 8'hec, 2, 32'h42, 32'h69, 0, 0, 16'h0006, 0, 0, 0);
    vecs[1] = mk(0, 8'h10, 2, 32'h11223344, 32'hAABBCCDD, 0, 0, 16'h000c, 0, 0, 0);
    vecs[2] = mk(0, 8'h05, 0, 0, 0, 0, 0, 16'h0004, 0, 0, 0);
    vecs[3] = mk(0, 8'h10, 2, 32'h11223344, 32'hAABBCCDD, 0, 0, 16'h000c, 1, 1, 0);
    vecs[4] = mk(0, 8'ha5, 3, 32'hdeadbeef, 32'h01020304, 32'hffffffff, 0, 16'h0010, 1, 0, 0);
    vecs[5] = mk(0, 8'h7e, 4, 32'h0badf00d, 32'h12345678, 32'h9abcdef0, 32'h0f1e2d3c,
                 16'h0014, 0, 1, 0);
    vecs[6] = mk(1, 8'h81, 3, 32'h01, 32'h02, 32'h03, 0, 16'h0007, 1, 1, 0);
    vecs[7] = mk(0, 8'h10, 2, 32'h11223344, 32'hAABBCCDD, 0, 0, 16'h000c, 0, 0, 4);
    vecs[8] = mk(0, 8'h10, 2, 32'h11223344, 32'hAABBCCDD, 0, 0, 16'h000c, 0, 0, 0);
    vecs[9] = mk(0, 8'h33, 1, 32'h00000000, 0, 0, 0, 16'h0008, 0, 0, 0);

    reset_i = 1'b0;
    drive(1'b0, 8'h00, 8'h00, 1'b0, 32'h0, 1'b0, 1'b1);
    repeat (3) @(posedge clk);
    #1 reset_i = 1'b1;
    @(negedge clk);
    check("reset valid", int'(valid), 0);
    check("reset data", int'(data), 0);
    check("reset busy", int'(busy), 0);
    check("reset operand_ready", int'(operand_ready), 0);
    check("reset cmd_ready", int'(cmd_ready), 1);
    check("reset valid8", int'(valid8), 0);
    check("reset data8", int'(data8), 0);
    check("reset busy8", int'(busy8), 0);
    check("reset operand_ready8", int'(operand_ready8), 0);
    check("reset cmd_ready8", int'(cmd_ready8), 1);

    for (int i = 0; i < 10; i++) run_pkt(vecs[i], $sformatf("vec%0d", i));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
